// File: rtl/baud_ctrl.sv
// UART baud timebase controller: divisor counter, oversample/bit ticks, and a
// host config handshake whose changes are deferred to the next bit boundary.
module baud_ctrl #(
  parameter int unsigned     BITS        = 16,
  parameter int unsigned     OVS         = 16,
  parameter int unsigned     OVS_W       = 4,
  parameter logic [BITS-1:0] DEFAULT_DIV = BITS'(650)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [BITS-1:0] cfg_div,
  input  logic            cfg_run,
  input  logic            sync_clr,
  output logic            tick_os,
  output logic            tick_bit,
  output logic            busy,
  output logic            pend,
  output logic [BITS-1:0] cur_div
);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  localparam logic [OVS_W-1:0] OS_LAST = OVS_W'(OVS - 1);

  state_e           state_q, state_d;
  logic [BITS-1:0]  cnt_q, cnt_d;
  logic [OVS_W-1:0] os_cnt_q, os_cnt_d;
  logic [BITS-1:0]  cur_div_q, cur_div_d;
  logic [BITS-1:0]  pend_div_q, pend_div_d;
  logic             pend_run_q, pend_run_d;
  logic             busy_q, busy_d;
  logic             pend_q, pend_d;
  logic             ready_q, ready_d;

  logic             xfer_c;
  logic             tick_os_c;
  logic             tick_bit_c;

  // Ticks come straight off the counters; sync_clr masks the cycle it is applied in.
  assign xfer_c     = cfg_valid && ready_q;
  assign tick_os_c  = (state_q != ST_STOP) && !sync_clr && (cnt_q == cur_div_q);
  assign tick_bit_c = tick_os_c && (os_cnt_q == OS_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    os_cnt_d   = os_cnt_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    pend_run_d = pend_run_q;

    case (state_q)
      ST_STOP: begin
        cnt_d    = '0;
        os_cnt_d = '0;
        if (xfer_c) begin
          cur_div_d = cfg_div;
          if (cfg_run) begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN, ST_PEND: begin
        if (sync_clr) begin
          cnt_d    = '0;
          os_cnt_d = '0;
        end else if (tick_os_c) begin
          cnt_d    = '0;
          os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OVS_W'(1);
        end else begin
          cnt_d = cnt_q + BITS'(1);
        end

        // A queued update lands only on a delivered bit tick.
        if (state_q == ST_RUN && xfer_c) begin
          pend_div_d = cfg_div;
          pend_run_d = cfg_run;
          state_d    = ST_PEND;
        end else if (state_q == ST_PEND && tick_bit_c) begin
          cur_div_d = pend_div_q;
          cnt_d     = '0;
          os_cnt_d  = '0;
          state_d   = pend_run_q ? ST_RUN : ST_STOP;
        end
      end

      default: begin
        state_d = ST_STOP;
      end
    endcase

    busy_d  = (state_d != ST_STOP);
    pend_d  = (state_d == ST_PEND);
    ready_d = (state_d != ST_PEND);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_STOP;
      cnt_q      <= '0;
      os_cnt_q   <= '0;
      cur_div_q  <= DEFAULT_DIV;
      pend_div_q <= '0;
      pend_run_q <= 1'b0;
      busy_q     <= 1'b0;
      pend_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      os_cnt_q   <= os_cnt_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      pend_run_q <= pend_run_d;
      busy_q     <= busy_d;
      pend_q     <= pend_d;
      ready_q    <= ready_d;
    end
  end

  assign tick_os   = tick_os_c;
  assign tick_bit  = tick_bit_c;
  assign busy      = busy_q;
  assign pend      = pend_q;
  assign cfg_ready = ready_q;
  assign cur_div   = cur_div_q;

endmodule

// File: tb/tb_baud_ctrl.sv
// Self-checking bench for baud_ctrl: directed table, multi-cycle corner cases,
// and randomized traffic against a phase-arithmetic reference model.
module tb_baud_ctrl;

  localparam int OVS = 16;

  logic        clk;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_div;
  logic        cfg_run;
  logic        sync_clr;
  logic        tick_os;
  logic        tick_bit;
  logic        busy;
  logic        pend;
  logic [15:0] cur_div;

  baud_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_div  (cfg_div),
    .cfg_run  (cfg_run),
    .sync_clr (sync_clr),
    .tick_os  (tick_os),
    .tick_bit (tick_bit),
    .busy     (busy),
    .pend     (pend),
    .cur_div  (cur_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0=stop 1=run 2=pend; m_t = cycles since last phase origin.
  int m_mode, m_div, m_t, m_pdiv, m_prun;

  // Observed outputs from the most recent step.
  logic        o_os, o_bit, o_busy, o_pend, o_rdy;
  logic [15:0] o_div;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        r;
    logic        s;
    logic        e_os;
    logic        e_bit;
    logic        e_busy;
    logic        e_pend;
    logic        e_rdy;
    logic [15:0] e_div;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_div = 650; m_t = 0; m_pdiv = 0; m_prun = 0;
  endtask

  // One clock cycle: drive, sample at negedge, compare to model, advance model.
  task automatic step(input logic v, input logic [15:0] d, input logic r, input logic s);
    bit e_os, e_bit, xfer;
    cfg_valid = v; cfg_div = d; cfg_run = r; sync_clr = s;
    @(negedge clk);
    e_os  = (m_mode != 0) && !s && (((m_t + 1) % (m_div + 1)) == 0);
    e_bit = e_os && ((((m_t + 1) / (m_div + 1)) % OVS) == 0);
    o_os = tick_os; o_bit = tick_bit; o_busy = busy; o_pend = pend;
    o_rdy = cfg_ready; o_div = cur_div;
    chk("tick_os", o_os, e_os);
    chk("tick_bit", o_bit, e_bit);
    chk("busy", o_busy, m_mode != 0);
    chk("pend", o_pend, m_mode == 2);
    chk("cfg_ready", o_rdy, m_mode != 2);
    chk("cur_div", o_div, m_div);
    xfer = v && (m_mode != 2);
    if (m_mode == 0) begin
      m_t = 0;
      if (xfer) begin
        m_div = int'(d);
        if (r) m_mode = 1;
      end
    end else begin
      if (s) m_t = 0; else m_t++;
      if (m_mode == 1 && xfer) begin
        m_pdiv = int'(d); m_prun = int'(r); m_mode = 2;
      end else if (m_mode == 2 && e_bit) begin
        m_div = m_pdiv; m_t = 0; m_mode = m_prun ? 1 : 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'd0, 1'b0, 1'b0);
  endtask

  // Idle until the chosen tick is seen; n = steps taken (bounded by maxc).
  task automatic wait_ev(input bit want_bit, input int maxc, output int n);
    n = 0;
    do begin
      step(1'b0, 16'd0, 1'b0, 1'b0);
      n++;
    end while (!(want_bit ? o_bit : o_os) && n < maxc);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cfg_valid = 1'b0; cfg_div = '0; cfg_run = 1'b0; sync_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, n_os, n_bit;
    do_reset();

    // Directed table: STOP config, start at div=3, then a RUN update that queues.
    tbl.push_back('{1'b1, 16'd100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd650});
    tbl.push_back('{1'b1, 16'd3,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd100});
    tbl.push_back('{1'b0, 16'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd3});
    tbl.push_back('{1'b0, 16'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd3});
    tbl.push_back('{1'b0, 16'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd3});
    tbl.push_back('{1'b0, 16'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd3});
    tbl.push_back('{1'b1, 16'd7,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd3});
    tbl.push_back('{1'b0, 16'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd3});
    tbl.push_back('{1'b1, 16'd9,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd3});
    tbl.push_back('{1'b0, 16'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd3});
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].s);
      chk($sformatf("tbl%0d_os", i), o_os, tbl[i].e_os);
      chk($sformatf("tbl%0d_bit", i), o_bit, tbl[i].e_bit);
      chk($sformatf("tbl%0d_busy", i), o_busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_pend", i), o_pend, tbl[i].e_pend);
      chk($sformatf("tbl%0d_rdy", i), o_rdy, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_div", i), o_div, tbl[i].e_div);
    end

    // Start at div=3: first tick 4 cycles after transfer, bit every 64.
    do_reset();
    step(1'b1, 16'd3, 1'b1, 1'b0);
    wait_ev(1'b0, 20, n);  chk("first_tick_os", n, 4);
    wait_ev(1'b0, 20, n);  chk("tick_os_period", n, 4);
    wait_ev(1'b1, 200, n); chk("first_tick_bit", n, 56);
    wait_ev(1'b1, 200, n); chk("tick_bit_period", n, 64);

    // Mid-bit update to div=1: held until the next tick_bit, then 2-cycle period.
    idle(10);
    step(1'b1, 16'd1, 1'b1, 1'b0);
    step(1'b0, 16'd0, 1'b0, 1'b0);
    chk("midbit_pend", o_pend, 1);
    chk("midbit_ready", o_rdy, 0);
    wait_ev(1'b1, 200, n); chk("pend_apply_bit", n, 52);
    chk("old_div_at_apply", o_div, 3);
    wait_ev(1'b0, 20, n);  chk("new_tick_period", n, 2);
    chk("new_cur_div", o_div, 1);

    // Stop request: stops right after the next tick_bit, no ticks afterwards.
    do_reset();
    step(1'b1, 16'd3, 1'b1, 1'b0);
    wait_ev(1'b1, 200, n); chk("stop_pre_bit", n, 64);
    idle(5);
    step(1'b1, 16'd5, 1'b0, 1'b0);
    wait_ev(1'b1, 200, n); chk("stop_at_bit", n, 58);
    n_os = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 16'd0, 1'b0, 1'b0);
      if (o_os) n_os++;
    end
    chk("stopped_ticks", n_os, 0);
    chk("stopped_busy", o_busy, 0);
    chk("stopped_div", o_div, 5);

    // sync_clr at cnt=2, os_cnt=7.
    step(1'b1, 16'd3, 1'b1, 1'b0);
    wait_ev(1'b1, 200, n); chk("sync_pre_bit", n, 64);
    idle(30);
    step(1'b0, 16'd0, 1'b0, 1'b1);
    chk("sync_no_tick", o_os, 0);
    wait_ev(1'b0, 20, n);  chk("sync_next_tick", n, 4);
    wait_ev(1'b1, 200, n); chk("sync_next_bit", n, 60);

    // Pending update with sync_clr on the would-be tick_bit cycle.
    step(1'b1, 16'd2, 1'b1, 1'b0);
    idle(62);
    step(1'b0, 16'd0, 1'b0, 1'b1);
    chk("pend_sync_no_bit", o_bit, 0);
    step(1'b0, 16'd0, 1'b0, 1'b0);
    chk("pend_still", o_pend, 1);
    wait_ev(1'b1, 200, n); chk("pend_sync_apply", n, 63);
    chk("pend_sync_old_div", o_div, 3);
    step(1'b0, 16'd0, 1'b0, 1'b0);
    chk("pend_sync_new_div", o_div, 2);

    // div=0: tick every cycle, tick_bit every 16; then async reset mid-run.
    do_reset();
    step(1'b1, 16'd0, 1'b1, 1'b0);
    n_os = 0; n_bit = 0;
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 16'd0, 1'b0, 1'b0);
      if (o_os) n_os++;
      if (o_bit) n_bit++;
    end
    chk("div0_os_count", n_os, 32);
    chk("div0_bit_count", n_bit, 2);
    #2 reset = 1'b0;
    #1;
    chk("arst_tick_os", tick_os, 0);
    chk("arst_tick_bit", tick_bit, 0);
    chk("arst_busy", busy, 0);
    chk("arst_pend", pend, 0);
    chk("arst_ready", cfg_ready, 1);
    chk("arst_cur_div", cur_div, 650);
    do_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 3) == 0), 16'($urandom_range(0, 4)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
